// File: rtl/tlb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tlb_arb_pkg
// Brief    : Shared types and constants for the TLB lookup-port arbiter.
// Revision : 1.0  initial release
// ============================================================================
package tlb_arb_pkg;

    // Default exception-cause width and the "no exception" code
    localparam int                   EXC_W_DEF     = 7;
    localparam logic [EXC_W_DEF-1:0] EXCEPTION_NOP = 7'b1111111;

    // Maintenance operation codes presented by EX
    typedef enum logic [2:0] {
        MT_SRCH = 3'd0,
        MT_RD   = 3'd1,
        MT_WR   = 3'd2,
        MT_FILL = 3'd3,
        MT_INV  = 3'd4
    } mt_op_e;

    // Arbiter sequencing states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_IF_A     = 3'd1,
        ST_IF_B     = 3'd2,
        ST_DC       = 3'd3,
        ST_MT_EXEC  = 3'd4,
        ST_MT_FENCE = 3'd5
    } arb_state_e;

    // Lookup issued towards the TLB
    typedef struct packed {
        logic [31:0] vaddr;
        logic        store;
    } lk_req_t;

    // Lookup result returned by the TLB
    typedef struct packed {
        logic [31:0]          paddr;
        logic [EXC_W_DEF-1:0] exc;
    } lk_rsp_t;

endpackage : tlb_arb_pkg
`default_nettype wire

// File: rtl/tlb_arb_prio.sv
`default_nettype none
// ============================================================================
// Module   : tlb_arb_prio
// Brief    : Grant selection (mt > dc > if) with an icache starvation
//            counter that lets icache beat dcache after STARVE_MAX losses.
// Revision : 1.0  initial release
// ============================================================================
module tlb_arb_prio #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_idle,
    input  logic i_if_req,
    input  logic i_dc_req,
    input  logic i_mt_req,
    output logic o_if_gnt,
    output logic o_dc_gnt,
    output logic o_mt_gnt
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] c_STARVE_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_starved;

    assign w_starved = (r_starve_cnt == c_STARVE_MAX);

    // Grants only in IDLE; a starved icache overtakes dcache but never mt
    always_comb begin
        o_mt_gnt = i_idle && i_mt_req;
        o_dc_gnt = i_idle && !i_mt_req && i_dc_req && !(i_if_req && w_starved);
        o_if_gnt = i_idle && !i_mt_req && i_if_req && (!i_dc_req || w_starved);
    end

    // Count cycles icache waits (including busy cycles); saturate, clear on grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (o_if_gnt) begin
            r_starve_cnt <= '0;
        end else if (i_if_req && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

endmodule : tlb_arb_prio
`default_nettype wire

// File: rtl/tlb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tlb_port_arbiter
// Brief    : Shares the single TLB lookup port between icache (two vaddrs),
//            dcache and EX maintenance ops; fences one cycle after each op.
//            Optional: TLB_ARB_PAGE_MERGE_EN merges same-4KiB-page icache
//            requests into a single lookup.
// Revision : 1.0  initial release
// ============================================================================
module tlb_port_arbiter
    import tlb_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int EXC_W      = EXC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    // icache
    input  logic             if_req,
    input  logic [31:0]      if_vaddr_a,
    input  logic [31:0]      if_vaddr_b,
    output logic             if_gnt,
    output logic             if_rsp_valid,
    output logic [31:0]      if_paddr_a,
    output logic [31:0]      if_paddr_b,
    output logic [EXC_W-1:0] if_exc_a,
    output logic [EXC_W-1:0] if_exc_b,
    // dcache
    input  logic             dc_req,
    input  logic [31:0]      dc_vaddr,
    input  logic             dc_store,
    output logic             dc_gnt,
    output logic             dc_rsp_valid,
    output logic [31:0]      dc_paddr,
    output logic [EXC_W-1:0] dc_exc,
    // maintenance
    input  logic             mt_req,
    input  logic [2:0]       mt_op,
    output logic             mt_gnt,
    output logic             mt_done,
    // TLB lookup port
    output logic             lk_valid,
    output logic [31:0]      lk_vaddr,
    output logic             lk_store,
    input  logic [31:0]      lk_paddr,
    input  logic [EXC_W-1:0] lk_exc,
    // TLB maintenance strobes
    output logic             tlb_srch_en,
    output logic             tlb_rd_en,
    output logic             tlb_wr_en,
    output logic             tlb_fill_en,
    output logic             tlb_inv_en
);

    localparam logic [EXC_W-1:0] c_EXC_NOP = {EXC_W{1'b1}};

    arb_state_e       r_state, w_state_nxt;
    logic             w_idle, w_if_gnt, w_dc_gnt, w_mt_gnt;
    logic             w_same_page, r_same_page;
    logic [31:0]      r_vaddr_b;
    logic [2:0]       r_mt_op;
    logic [31:0]      r_a_paddr;
    logic [EXC_W-1:0] r_a_exc;

    // Held copies of the last delivered responses
    logic [31:0]      r_if_paddr_a, r_if_paddr_b, r_dc_paddr;
    logic [EXC_W-1:0] r_if_exc_a, r_if_exc_b, r_dc_exc;

    // Combinational outputs from the FSM
    lk_req_t          w_lk;
    logic             w_lk_valid, w_if_rsp, w_dc_rsp, w_mt_done;
    logic [31:0]      w_if_pa_a, w_if_pa_b, w_dc_pa;
    logic [EXC_W-1:0] w_if_ex_a, w_if_ex_b, w_dc_ex;
    logic             w_srch, w_rd, w_wr, w_fill, w_inv;

    assign w_idle = (r_state == ST_IDLE);

    tlb_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk      (clk),
        .rst      (rst),
        .i_idle   (w_idle),
        .i_if_req (if_req),
        .i_dc_req (dc_req),
        .i_mt_req (mt_req),
        .o_if_gnt (w_if_gnt),
        .o_dc_gnt (w_dc_gnt),
        .o_mt_gnt (w_mt_gnt)
    );

`ifdef TLB_ARB_PAGE_MERGE_EN
    assign w_same_page = (if_vaddr_a[31:12] == if_vaddr_b[31:12]);
`else
    assign w_same_page = 1'b0;
`endif

    // State register; reset aborts any in-flight operation without a response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request capture, first-half icache result and held response values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vaddr_b    <= '0;
            r_same_page  <= 1'b0;
            r_mt_op      <= '0;
            r_a_paddr    <= '0;
            r_a_exc      <= c_EXC_NOP;
            r_if_paddr_a <= '0;
            r_if_paddr_b <= '0;
            r_if_exc_a   <= c_EXC_NOP;
            r_if_exc_b   <= c_EXC_NOP;
            r_dc_paddr   <= '0;
            r_dc_exc     <= c_EXC_NOP;
        end else begin
            if (w_if_gnt) begin
                r_vaddr_b   <= if_vaddr_b;
                r_same_page <= w_same_page;
            end
            if (w_mt_gnt) begin
                r_mt_op <= mt_op;
            end
            if (r_state == ST_IF_A) begin
                r_a_paddr <= lk_paddr;
                r_a_exc   <= lk_exc;
            end
            if (w_if_rsp) begin
                r_if_paddr_a <= w_if_pa_a;
                r_if_paddr_b <= w_if_pa_b;
                r_if_exc_a   <= w_if_ex_a;
                r_if_exc_b   <= w_if_ex_b;
            end
            if (w_dc_rsp) begin
                r_dc_paddr <= w_dc_pa;
                r_dc_exc   <= w_dc_ex;
            end
        end
    end

    // Next-state, lookup mux, responses and maintenance strobes
    always_comb begin
        w_state_nxt = r_state;
        w_lk_valid  = 1'b0;
        w_lk        = '0;
        w_if_rsp    = 1'b0;
        w_if_pa_a   = r_if_paddr_a;
        w_if_pa_b   = r_if_paddr_b;
        w_if_ex_a   = r_if_exc_a;
        w_if_ex_b   = r_if_exc_b;
        w_dc_rsp    = 1'b0;
        w_dc_pa     = r_dc_paddr;
        w_dc_ex     = r_dc_exc;
        w_mt_done   = 1'b0;
        w_srch      = 1'b0;
        w_rd        = 1'b0;
        w_wr        = 1'b0;
        w_fill      = 1'b0;
        w_inv       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_mt_gnt) begin
                    w_state_nxt = ST_MT_EXEC;
                end else if (w_dc_gnt) begin
                    w_lk_valid  = 1'b1;
                    w_lk.vaddr  = dc_vaddr;
                    w_lk.store  = dc_store;
                    w_state_nxt = ST_DC;
                end else if (w_if_gnt) begin
                    w_lk_valid  = 1'b1;
                    w_lk.vaddr  = if_vaddr_a;
                    w_state_nxt = ST_IF_A;
                end
            end
            ST_IF_A: begin
                if (flush) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_same_page) begin
                    // One translation covers both fetch addresses
                    w_if_rsp    = 1'b1;
                    w_if_pa_a   = lk_paddr;
                    w_if_ex_a   = lk_exc;
                    w_if_pa_b   = {lk_paddr[31:12], r_vaddr_b[11:12-12]};
                    w_if_ex_b   = lk_exc;
                    w_state_nxt = ST_IDLE;
                end else begin
                    // b is looked up even when a faulted
                    w_lk_valid  = 1'b1;
                    w_lk.vaddr  = r_vaddr_b;
                    w_state_nxt = ST_IF_B;
                end
            end
            ST_IF_B: begin
                if (!flush) begin
                    w_if_rsp  = 1'b1;
                    w_if_pa_a = r_a_paddr;
                    w_if_ex_a = r_a_exc;
                    w_if_pa_b = lk_paddr;
                    w_if_ex_b = lk_exc;
                end
                w_state_nxt = ST_IDLE;
            end
            ST_DC: begin
                w_dc_rsp    = 1'b1;
                w_dc_pa     = lk_paddr;
                w_dc_ex     = lk_exc;
                w_state_nxt = ST_IDLE;
            end
            ST_MT_EXEC: begin
                case (r_mt_op)
                    MT_SRCH: w_srch = 1'b1;
                    MT_RD:   w_rd   = 1'b1;
                    MT_WR:   w_wr   = 1'b1;
                    MT_FILL: w_fill = 1'b1;
                    MT_INV:  w_inv  = 1'b1;
                    default: ;
                endcase
                w_state_nxt = ST_MT_FENCE;
            end
            ST_MT_FENCE: begin
                // Fence cycle: the TLB write settles before the next lookup
                w_mt_done   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign if_gnt       = w_if_gnt;
    assign dc_gnt       = w_dc_gnt;
    assign mt_gnt       = w_mt_gnt;
    assign lk_valid     = w_lk_valid;
    assign lk_vaddr     = w_lk.vaddr;
    assign lk_store     = w_lk.store;
    assign if_rsp_valid = w_if_rsp;
    assign if_paddr_a   = w_if_pa_a;
    assign if_paddr_b   = w_if_pa_b;
    assign if_exc_a     = w_if_ex_a;
    assign if_exc_b     = w_if_ex_b;
    assign dc_rsp_valid = w_dc_rsp;
    assign dc_paddr     = w_dc_pa;
    assign dc_exc       = w_dc_ex;
    assign mt_done      = w_mt_done;
    assign tlb_srch_en  = w_srch;
    assign tlb_rd_en    = w_rd;
    assign tlb_wr_en    = w_wr;
    assign tlb_fill_en  = w_fill;
    assign tlb_inv_en   = w_inv;

endmodule : tlb_port_arbiter
`default_nettype wire

// File: tb/tb_tlb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlb_port_arbiter
// Brief    : Directed, table-driven bench for tlb_port_arbiter plus short
//            hand sequences for starvation, flush and mid-op reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_tlb_port_arbiter;

    localparam logic [6:0] NOP = 7'h7F;

    // Control-bit masks: {if_gnt,dc_gnt,mt_gnt,lk_valid,srch,rd,wr,fill,inv,mt_done,if_rsp,dc_rsp}
    localparam logic [11:0] C_IFG  = 12'h800, C_DCG  = 12'h400, C_MTG = 12'h200;
    localparam logic [11:0] C_LKV  = 12'h100, C_SRCH = 12'h080;
    localparam logic [11:0] C_WR   = 12'h020, C_FILL = 12'h010;
    localparam logic [11:0] C_DONE = 12'h004, C_IFR  = 12'h002, C_DCR = 12'h001;

    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic        if_req = 1'b0, dc_req = 1'b0, mt_req = 1'b0, dc_store = 1'b0;
    logic [31:0] if_vaddr_a = '0, if_vaddr_b = '0, dc_vaddr = '0, lk_paddr = '0;
    logic [2:0]  mt_op = '0;
    logic [6:0]  lk_exc = NOP;
    logic        if_gnt, if_rsp_valid, dc_gnt, dc_rsp_valid, mt_gnt, mt_done;
    logic        lk_valid, lk_store;
    logic [31:0] if_paddr_a, if_paddr_b, dc_paddr, lk_vaddr;
    logic [6:0]  if_exc_a, if_exc_b, dc_exc;
    logic        tlb_srch_en, tlb_rd_en, tlb_wr_en, tlb_fill_en, tlb_inv_en;
    logic [11:0] ctl;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tlb_port_arbiter #(.STARVE_MAX(4), .EXC_W(7)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_req(if_req), .if_vaddr_a(if_vaddr_a), .if_vaddr_b(if_vaddr_b),
        .if_gnt(if_gnt), .if_rsp_valid(if_rsp_valid),
        .if_paddr_a(if_paddr_a), .if_paddr_b(if_paddr_b),
        .if_exc_a(if_exc_a), .if_exc_b(if_exc_b),
        .dc_req(dc_req), .dc_vaddr(dc_vaddr), .dc_store(dc_store),
        .dc_gnt(dc_gnt), .dc_rsp_valid(dc_rsp_valid),
        .dc_paddr(dc_paddr), .dc_exc(dc_exc),
        .mt_req(mt_req), .mt_op(mt_op), .mt_gnt(mt_gnt), .mt_done(mt_done),
        .lk_valid(lk_valid), .lk_vaddr(lk_vaddr), .lk_store(lk_store),
        .lk_paddr(lk_paddr), .lk_exc(lk_exc),
        .tlb_srch_en(tlb_srch_en), .tlb_rd_en(tlb_rd_en), .tlb_wr_en(tlb_wr_en),
        .tlb_fill_en(tlb_fill_en), .tlb_inv_en(tlb_inv_en)
    );

    assign ctl = {if_gnt, dc_gnt, mt_gnt, lk_valid, tlb_srch_en, tlb_rd_en,
                  tlb_wr_en, tlb_fill_en, tlb_inv_en, mt_done, if_rsp_valid, dc_rsp_valid};

    typedef struct {
        string       name;
        logic        if_req, dc_req, mt_req, flush, dc_st;
        logic [2:0]  mt_op;
        logic [31:0] if_va, if_vb, dc_va, lk_pa;
        logic [6:0]  lk_ex;
        logic [11:0] e_ctl;
        logic [31:0] e_lk_va;
        logic        e_lk_st;
        logic [31:0] e_pa_a, e_pa_b, e_dc_pa;
        logic [6:0]  e_ex_a, e_ex_b, e_dc_ex;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t nv(input string n, input logic [11:0] c);
        vec_t v;
        v.name = n; v.e_ctl = c;
        v.if_req = 0; v.dc_req = 0; v.mt_req = 0; v.flush = 0; v.dc_st = 0;
        v.mt_op = 0; v.if_va = 0; v.if_vb = 0; v.dc_va = 0; v.lk_pa = 0;
        v.lk_ex = NOP; v.e_lk_va = 0; v.e_lk_st = 0;
        v.e_pa_a = 0; v.e_pa_b = 0; v.e_dc_pa = 0;
        v.e_ex_a = NOP; v.e_ex_b = NOP; v.e_dc_ex = NOP;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        @(negedge clk);
        if_req = v.if_req; dc_req = v.dc_req; mt_req = v.mt_req; flush = v.flush;
        dc_store = v.dc_st; mt_op = v.mt_op; if_vaddr_a = v.if_va; if_vaddr_b = v.if_vb;
        dc_vaddr = v.dc_va; lk_paddr = v.lk_pa; lk_exc = v.lk_ex;
        #2;
        chk({v.name, ".ctl"}, 32'(ctl), 32'(v.e_ctl));
        if ((v.e_ctl & C_LKV) != 0) begin
            chk({v.name, ".lk_vaddr"}, lk_vaddr, v.e_lk_va);
            chk({v.name, ".lk_store"}, 32'(lk_store), 32'(v.e_lk_st));
        end
        if ((v.e_ctl & C_IFR) != 0) begin
            chk({v.name, ".pa_a"}, if_paddr_a, v.e_pa_a);
            chk({v.name, ".pa_b"}, if_paddr_b, v.e_pa_b);
            chk({v.name, ".ex_a"}, 32'(if_exc_a), 32'(v.e_ex_a));
            chk({v.name, ".ex_b"}, 32'(if_exc_b), 32'(v.e_ex_b));
        end
        if ((v.e_ctl & C_DCR) != 0) begin
            chk({v.name, ".dc_pa"}, dc_paddr, v.e_dc_pa);
            chk({v.name, ".dc_ex"}, 32'(dc_exc), 32'(v.e_dc_ex));
        end
    endtask

    task automatic idle_inputs();
        if_req = 0; dc_req = 0; mt_req = 0; flush = 0; dc_store = 0; mt_op = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v;
        logic [2:0]  exp_g [0:7];
        logic [11:0] strobe;

        // ---------------- vector table ----------------
        v = nv("dc_gnt", C_DCG | C_LKV); v.dc_req = 1; v.dc_va = 32'h1C00_0040;
        v.e_lk_va = 32'h1C00_0040; tbl.push_back(v);
        v = nv("dc_rsp", C_DCR); v.lk_pa = 32'h0000_0040; v.e_dc_pa = 32'h0000_0040;
        tbl.push_back(v);
        v = nv("idle0", 12'h000); tbl.push_back(v);

        v = nv("mt_beats_dc", C_MTG); v.mt_req = 1; v.mt_op = 3'd2;
        v.dc_req = 1; v.dc_va = 32'h2000_0008; v.dc_st = 1; tbl.push_back(v);
        v = nv("mt_exec_wr", C_WR); v.dc_req = 1; v.dc_va = 32'h2000_0008; v.dc_st = 1;
        tbl.push_back(v);
        v = nv("mt_fence", C_DONE); v.dc_req = 1; v.dc_va = 32'h2000_0008; v.dc_st = 1;
        tbl.push_back(v);
        v = nv("dc_after_mt", C_DCG | C_LKV); v.dc_req = 1; v.dc_va = 32'h2000_0008;
        v.dc_st = 1; v.e_lk_va = 32'h2000_0008; v.e_lk_st = 1; tbl.push_back(v);
        v = nv("dc_rsp_st", C_DCR); v.lk_pa = 32'h8000_1008; v.lk_ex = 7'h05;
        v.e_dc_pa = 32'h8000_1008; v.e_dc_ex = 7'h05; tbl.push_back(v);

        // icache, two pages; a faults but b is still looked up
        v = nv("if_gnt_x", C_IFG | C_LKV); v.if_req = 1; v.if_va = 32'h1C00_0FF8;
        v.if_vb = 32'h1C00_1000; v.e_lk_va = 32'h1C00_0FF8; tbl.push_back(v);
        v = nv("if_a_x", C_LKV); v.lk_pa = 32'h0000_0FF8; v.lk_ex = 7'h02;
        v.e_lk_va = 32'h1C00_1000; tbl.push_back(v);
        v = nv("if_b_x", C_IFR); v.lk_pa = 32'h0000_3000; v.lk_ex = NOP;
        v.e_pa_a = 32'h0000_0FF8; v.e_ex_a = 7'h02; v.e_pa_b = 32'h0000_3000;
        v.e_ex_b = NOP; tbl.push_back(v);

        // icache, same page
        v = nv("if_gnt_s", C_IFG | C_LKV); v.if_req = 1; v.if_va = 32'h1C00_0FF8;
        v.if_vb = 32'h1C00_0FFC; v.e_lk_va = 32'h1C00_0FF8; tbl.push_back(v);
`ifdef TLB_ARB_PAGE_MERGE_EN
        v = nv("if_a_s", C_IFR); v.lk_pa = 32'h0000_5FF8; v.lk_ex = 7'h09;
        v.e_pa_a = 32'h0000_5FF8; v.e_pa_b = 32'h0000_5FFC;
        v.e_ex_a = 7'h09; v.e_ex_b = 7'h09; tbl.push_back(v);
`else
        v = nv("if_a_s", C_LKV); v.lk_pa = 32'h0000_5FF8; v.lk_ex = NOP;
        v.e_lk_va = 32'h1C00_0FFC; tbl.push_back(v);
        v = nv("if_b_s", C_IFR); v.lk_pa = 32'h0000_5FFC; v.lk_ex = 7'h09;
        v.e_pa_a = 32'h0000_5FF8; v.e_ex_a = NOP; v.e_pa_b = 32'h0000_5FFC;
        v.e_ex_b = 7'h09; tbl.push_back(v);
`endif
        v = nv("idle1", 12'h000); tbl.push_back(v);

        // every maintenance op code, including an unused one
        for (int op = 0; op < 6; op++) begin
            strobe = (op < 5) ? (C_SRCH >> op) : 12'h000;
            v = nv($sformatf("mt_gnt_op%0d", op), C_MTG); v.mt_req = 1; v.mt_op = 3'(op);
            tbl.push_back(v);
            v = nv($sformatf("mt_exec_op%0d", op), strobe); tbl.push_back(v);
            v = nv($sformatf("mt_done_op%0d", op), C_DONE); tbl.push_back(v);
        end

        // ---------------- reset ----------------
        @(negedge clk); #2;
        chk("rst.ctl", 32'(ctl), 32'h0);
        chk("rst.lk_vaddr", lk_vaddr, 32'h0);
        chk("rst.lk_store", 32'(lk_store), 32'h0);
        chk("rst.if_pa_a", if_paddr_a, 32'h0);
        chk("rst.if_pa_b", if_paddr_b, 32'h0);
        chk("rst.if_ex_a", 32'(if_exc_a), 32'(NOP));
        chk("rst.if_ex_b", 32'(if_exc_b), 32'(NOP));
        chk("rst.dc_pa", dc_paddr, 32'h0);
        chk("rst.dc_ex", 32'(dc_exc), 32'(NOP));
        @(negedge clk);
        rst = 0;

        // ---------------- table ----------------
        foreach (tbl[i]) apply_vec(tbl[i]);

        // ---------------- starvation: if and dc held ----------------
`ifdef TLB_ARB_PAGE_MERGE_EN
        exp_g = '{3'b010, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b010, 3'b000};
`else
        exp_g = '{3'b010, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b000, 3'b010};
`endif
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if_req = 1; dc_req = 1; if_vaddr_a = 32'h1000_0000; if_vaddr_b = 32'h1000_0004;
            dc_vaddr = 32'h3000_0010; lk_paddr = 32'h0; lk_exc = NOP;
            #2;
            chk($sformatf("starve_c%0d", i), 32'({if_gnt, dc_gnt, mt_gnt}), 32'(exp_g[i]));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle_inputs();
        end
        #2;
        chk("starve_settle.ctl", 32'(ctl), 32'h0);

        // ---------------- flush during IF_B ----------------
        @(negedge clk);
        if_req = 1; if_vaddr_a = 32'h1C00_0FF8; if_vaddr_b = 32'h1C00_1000;
        #2; chk("fl.if_gnt", 32'(if_gnt), 32'h1);
        @(negedge clk); if_req = 0;
        #2; chk("fl.b_issue", 32'(lk_valid), 32'h1);
        @(negedge clk); flush = 1; dc_req = 1; dc_vaddr = 32'h3000_0020;
        #2; chk("fl.no_rsp", 32'(if_rsp_valid), 32'h0);
        chk("fl.busy_no_dc_gnt", 32'(dc_gnt), 32'h0);
        @(negedge clk); flush = 0;
        #2; chk("fl.dc_gnt_next", 32'(dc_gnt), 32'h1);
        chk("fl.no_late_rsp", 32'(if_rsp_valid), 32'h0);
        @(negedge clk); dc_req = 0; flush = 1; lk_paddr = 32'h0000_7020; lk_exc = NOP;
        #2; chk("fl.dc_rsp_ignores_flush", 32'(dc_rsp_valid), 32'h1);
        chk("fl.dc_pa", dc_paddr, 32'h0000_7020);
        @(negedge clk); flush = 0;
        #2; chk("fl.idle", 32'(ctl), 32'h0);

        // ---------------- reset during MT_EXEC ----------------
        @(negedge clk); mt_req = 1; mt_op = 3'd3;
        #2; chk("rmt.gnt", 32'(mt_gnt), 32'h1);
        @(negedge clk); mt_req = 0;
        #2; chk("rmt.fill", 32'(ctl), 32'(C_FILL));
        #1 rst = 1;
        #1;
        chk("rmt.ctl", 32'(ctl), 32'h0);
        chk("rmt.dc_pa", dc_paddr, 32'h0);
        chk("rmt.dc_ex", 32'(dc_exc), 32'(NOP));
        chk("rmt.if_ex_a", 32'(if_exc_a), 32'(NOP));
        @(negedge clk); rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #2;
            chk($sformatf("rmt.no_done_c%0d", i), 32'(ctl), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule : tb_tlb_port_arbiter
`default_nettype wire
